sseg_scan_capture: RTL and testbench

//  Reader side of the 4-digit multiplexed 7-segment interface. Samples the

---
 rtl/sseg_scan_capture.sv | 154 +++++++++++++++
 tb/tb_sseg_scan_capture.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_capture.sv
// sseg_scan_capture: rebuilds the 16-bit hex value from a 4-digit multiplexed
// active-low 7-segment scan (anode + segment lines) for loopback/monitoring.
// Ports: clk, rst_n (async active-low), an_n[3:0], seg_n[6:0] in;
//        value[15:0], digit_vld[3:0], frame_pulse, bad_pattern out (all registered).
// Latency: STABLE_CYC+3 edges from pin change to output update; no backpressure.
// Optional macro SSEG_CAP_BLANK_EN: an all-off segment word is committed as a
// blank digit (clears digit_vld/mask bit) instead of flagging bad_pattern.
module sseg_scan_capture #(
   parameter int STABLE_CYC = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  an_n,
   input  logic [6:0]  seg_n,
   output logic [15:0] value,
   output logic [3:0]  digit_vld,
   output logic        frame_pulse,
   output logic        bad_pattern
);

   localparam int CW = $clog2(STABLE_CYC + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC);
   localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYC - 1);

   logic [10:0]   sync1, sync2, cand;
   logic [CW-1:0] cnt;
   logic [3:0]    mask;

   logic          same;
   logic          fire;
   logic          one_anode;
   logic [1:0]    sel;
   logic          glyph_ok;
   logic [3:0]    glyph_nib;
   logic          is_blank;
   logic [3:0]    mask_set;

   logic [15:0]   value_nxt;
   logic [3:0]    vld_nxt;
   logic [3:0]    mask_nxt;
   logic          frame_nxt;
   logic          bad_nxt;

   // Segment word (active-high, bit0=a) -> {valid, nibble}.
   function automatic logic [4:0] decode(input logic [6:0] s);
      case (s)
         7'h3F: decode = {1'b1, 4'h0};
         7'h06: decode = {1'b1, 4'h1};
         7'h5B: decode = {1'b1, 4'h2};
         7'h4F: decode = {1'b1, 4'h3};
         7'h66: decode = {1'b1, 4'h4};
         7'h6D: decode = {1'b1, 4'h5};
         7'h7D: decode = {1'b1, 4'h6};
         7'h07: decode = {1'b1, 4'h7};
         7'h7F: decode = {1'b1, 4'h8};
         7'h6F: decode = {1'b1, 4'h9};
         7'h77: decode = {1'b1, 4'hA};
         7'h7C: decode = {1'b1, 4'hB};
         7'h39: decode = {1'b1, 4'hC};
         7'h5E: decode = {1'b1, 4'hD};
         7'h79: decode = {1'b1, 4'hE};
         7'h71: decode = {1'b1, 4'hF};
         default: decode = 5'h00;
      endcase
   endfunction

   // Two-flop synchronizer, then the stability tracker on the synced word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         cand  <= '0;
         cnt   <= '0;
      end else begin
         sync1 <= {an_n, seg_n};
         sync2 <= sync1;
         if (same) begin
            if (cnt != CNT_MAX)
               cnt <= cnt + CW'(1);
         end else begin
            cand <= sync2;
            cnt  <= '0;
         end
      end
   end

   always_comb begin
      same = (sync2 == cand);
      // Only the CNT_PRE -> CNT_MAX step fires; saturation blocks repeats
      // until the word changes and a fresh window starts.
      fire = same && (cnt == CNT_PRE);

      one_anode = 1'b1;
      sel       = 2'd0;
      case (cand[10:7])
         4'b1110: sel = 2'd0;
         4'b1101: sel = 2'd1;
         4'b1011: sel = 2'd2;
         4'b0111: sel = 2'd3;
         default: one_anode = 1'b0;
      endcase

      {glyph_ok, glyph_nib} = decode(~cand[6:0]);
`ifdef SSEG_CAP_BLANK_EN
      is_blank = (cand[6:0] == 7'h7F);
`else
      is_blank = 1'b0;
`endif

      mask_set      = mask;
      mask_set[sel] = 1'b1;

      value_nxt = value;
      vld_nxt   = digit_vld;
      mask_nxt  = mask;
      frame_nxt = 1'b0;
      bad_nxt   = 1'b0;

      if (fire && one_anode) begin
         if (is_blank) begin
            vld_nxt[sel]  = 1'b0;
            mask_nxt[sel] = 1'b0;
         end else if (glyph_ok) begin
            value_nxt[{sel, 2'b00} +: 4] = glyph_nib;
            vld_nxt[sel] = 1'b1;
            if (mask_set == 4'hF) begin
               frame_nxt = 1'b1;
               mask_nxt  = 4'h0;
            end else begin
               mask_nxt  = mask_set;
            end
         end else begin
            bad_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value       <= '0;
         digit_vld   <= '0;
         mask        <= '0;
         frame_pulse <= 1'b0;
         bad_pattern <= 1'b0;
      end else begin
         value       <= value_nxt;
         digit_vld   <= vld_nxt;
         mask        <= mask_nxt;
         frame_pulse <= frame_nxt;
         bad_pattern <= bad_nxt;
      end
   end

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Bench for sseg_scan_capture: table of display words with expected outputs,
// checked through a due-cycle scoreboard, plus hand sequences for reset,
// exact latency and mid-window reset.
module tb_sseg_scan_capture;

   localparam int STABLE_CYC = 8;
   localparam int LAT        = STABLE_CYC + 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  an_n;
   logic [6:0]  seg_n;
   logic [15:0] value;
   logic [3:0]  digit_vld;
   logic        frame_pulse;
   logic        bad_pattern;

   sseg_scan_capture #(.STABLE_CYC(STABLE_CYC)) dut (
      .clk(clk), .rst_n(rst_n), .an_n(an_n), .seg_n(seg_n),
      .value(value), .digit_vld(digit_vld),
      .frame_pulse(frame_pulse), .bad_pattern(bad_pattern)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0]  an;
      logic [6:0]  seg;
      int          hold;
      logic [15:0] val;
      logic [3:0]  vld;
      logic        frm;
      logic        bd;
   } vec_t;

   typedef struct {
      int          due;
      int          idx;
      logic [15:0] val;
      logic [3:0]  vld;
      logic        frm;
      logic        bd;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[17];

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cyc %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic wait_cyc(input int n);
      do @(negedge clk); while (cyc < n);
   endtask

   task automatic apply_vec(input int idx);
      exp_t e;
      @(posedge clk);
      #1;
      an_n  = vecs[idx].an;
      seg_n = vecs[idx].seg;
      e.due = cyc + LAT;
      e.idx = idx;
      e.val = vecs[idx].val;
      e.vld = vecs[idx].vld;
      e.frm = vecs[idx].frm;
      e.bd  = vecs[idx].bd;
      sb.push_back(e);
      repeat (vecs[idx].hold - 1) @(posedge clk);
   endtask

   // Scoreboard consumer: compare on the due cycle, otherwise pulses must be low.
   initial begin
      forever begin
         @(negedge clk);
         if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("vec%0d value", e.idx), value, e.val);
            check($sformatf("vec%0d digit_vld", e.idx), {12'h0, digit_vld}, {12'h0, e.vld});
            check($sformatf("vec%0d frame_pulse", e.idx), {15'h0, frame_pulse}, {15'h0, e.frm});
            check($sformatf("vec%0d bad_pattern", e.idx), {15'h0, bad_pattern}, {15'h0, e.bd});
         end else if (frame_pulse || bad_pattern) begin
            check("stray_pulse", {14'h0, frame_pulse, bad_pattern}, 16'h0);
         end
      end
   end

   initial begin
      repeat (20000) @(posedge clk);
      $display("FAIL watchdog: cycle budget expired at cyc %0d, expected completion", cyc);
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "timeout");
   end

   initial begin
      int a;
      // Glyph encodings on seg_n are the bitwise inverse of the active-high table.
      vecs[0]  = '{4'h7, 7'h79, 10, 16'h1000, 4'h8, 1'b0, 1'b0};
      vecs[1]  = '{4'hB, 7'h24, 10, 16'h1200, 4'hC, 1'b0, 1'b0};
      vecs[2]  = '{4'hD, 7'h30, 10, 16'h1230, 4'hE, 1'b0, 1'b0};
      vecs[3]  = '{4'hE, 7'h19, 10, 16'h1234, 4'hF, 1'b1, 1'b0};
      vecs[4]  = '{4'h7, 7'h08, 10, 16'hA234, 4'hF, 1'b0, 1'b0};
      vecs[5]  = '{4'h7, 7'h0E, 10, 16'hF234, 4'hF, 1'b0, 1'b0};
      vecs[6]  = '{4'hB, 7'h24, 10, 16'hF234, 4'hF, 1'b0, 1'b0};
      vecs[7]  = '{4'hD, 7'h30, 10, 16'hF234, 4'hF, 1'b0, 1'b0};
      vecs[8]  = '{4'hE, 7'h19, 10, 16'hF234, 4'hF, 1'b1, 1'b0};
      vecs[9]  = '{4'hD, 7'h12,  8, 16'hF234, 4'hF, 1'b0, 1'b0};
      vecs[10] = '{4'hD, 7'h02, 10, 16'hF264, 4'hF, 1'b0, 1'b0};
      vecs[11] = '{4'hD, 7'h12,  9, 16'hF254, 4'hF, 1'b0, 1'b0};
      vecs[12] = '{4'h7, 7'h36, 12, 16'hF254, 4'hF, 1'b0, 1'b1};
      vecs[13] = '{4'hC, 7'h24, 20, 16'hF254, 4'hF, 1'b0, 1'b0};
      vecs[14] = '{4'h0, 7'h24, 12, 16'hF254, 4'hF, 1'b0, 1'b0};
`ifdef SSEG_CAP_BLANK_EN
      vecs[15] = '{4'hB, 7'h7F, 12, 16'hF254, 4'hB, 1'b0, 1'b0};
`else
      vecs[15] = '{4'hB, 7'h7F, 12, 16'hF254, 4'hF, 1'b0, 1'b1};
`endif
      vecs[16] = '{4'hB, 7'h78, 10, 16'hF754, 4'hF, 1'b0, 1'b0};

      // Reset with active inputs, then idle.
      rst_n = 1'b0;
      an_n  = 4'hE;
      seg_n = 7'h24;
      repeat (4) @(posedge clk);
      #1;
      check("reset value", value, 16'h0);
      check("reset flags", {10'h0, digit_vld, frame_pulse, bad_pattern}, 16'h0);
      an_n  = 4'hF;
      seg_n = 7'h7F;
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("idle value", value, 16'h0);
      check("idle flags", {12'h0, digit_vld}, 16'h0);

      // Single digit with exact latency.
      @(posedge clk);
      #1;
      an_n  = 4'hE;
      seg_n = 7'h24;
      a = cyc;
      wait_cyc(a + LAT - 1);
      check("t2 early value", value, 16'h0);
      check("t2 early vld", {12'h0, digit_vld}, 16'h0);
      wait_cyc(a + LAT);
      check("t2 value", value, 16'h0002);
      check("t2 vld", {12'h0, digit_vld}, 16'h0001);
      wait_cyc(a + LAT + 3);
      check("t2 hold value", value, 16'h0002);

      // Reset in the middle of a valid window; commit only after a fresh window.
      @(posedge clk);
      #1;
      seg_n = 7'h10;
      a = cyc;
      wait_cyc(a + 6);
      rst_n = 1'b0;
      #1;
      check("midreset value", value, 16'h0);
      check("midreset vld", {12'h0, digit_vld}, 16'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      a = cyc;
      wait_cyc(a + LAT - 1);
      check("postreset early", value, 16'h0);
      wait_cyc(a + LAT);
      check("postreset value", value, 16'h0009);
      check("postreset vld", {12'h0, digit_vld}, 16'h0001);

      // Clean reset so the frame mask starts empty for the scan table.
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      an_n  = 4'hF;
      seg_n = 7'h7F;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);

      for (int i = 0; i < 17; i++) apply_vec(i);

      @(posedge clk);
      #1;
      an_n  = 4'hF;
      seg_n = 7'h7F;
      for (int k = 0; k < 100 && sb.size() > 0; k++) @(negedge clk);
      if (sb.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
